uart_rx_deframer: RTL and testbench

//   Serial-to-parallel UART receiver, 8N1, LSB first. Downstream partner of the

---
 rtl/uart_rx_deframer.sv | 112 +++++++++++
 tb/tb_uart_rx_deframer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receiver with midpoint sampling, valid/ready output
// Flags framing errors (stop bit low) and overruns (byte completed while output is held).
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s, rx_prev;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shreg, shreg_next;
  logic            good_stop, bad_stop;
  logic            tick_half, tick_bit;

  assign tick_half = (cnt == CW'(HALF - 1));
  assign tick_bit  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CW'(1);
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    good_stop    = 1'b0;
    bad_stop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        // Only a fresh 1->0 edge starts a frame, so a held-low line never retriggers.
        if (rx_prev && !rx_s) state_next = START;
      end
      START: begin
        if (tick_half) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_bit) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (tick_bit) begin
          cnt_next   = '0;
          state_next = IDLE;
          good_stop  = rx_s;
          bad_stop   = !rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good_stop && valid && !ready;
      if (good_stop && (!valid || ready)) begin
        dout  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
// Frames are driven as 8N1 serial bits; consumed bytes are checked against an expected queue.
module tb_uart_rx_deframer;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  // Posedges from driving the start bit to the edge that loads valid:
  // 2 sync flops + 1 detect edge + HALF + 9 bit periods.
  localparam int DLV  = 3 + HALF + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic       hold_chk = 1'b0;
  logic [7:0] held = 8'h00;

  uart_rx_deframer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (valid && ready) obs_q.push_back(dout);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun) begin
        vectors++;
        if (frame_err && overrun) begin
          miscompares++;
          $display("FAIL flags_exclusive: frame_err=%b overrun=%b, required not both", frame_err, overrun);
        end
      end
      if (hold_chk) begin
        vectors++;
        if (valid !== 1'b1 || dout !== held) begin
          miscompares++;
          $display("FAIL hold_stable: valid=%b dout=%h, required valid=1 dout=%h", valid, dout, held);
        end
      end
      hold_chk = valid && !ready;
      held     = dout;
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic idle_after);
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (C) @(posedge clk);
    #1;
    rx = idle_after;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_scoreboard();
    obs_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    vectors++;
    if ({dout, valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: dout=%h valid=%b fe=%b ov=%b busy=%b, required all 0",
               dout, valid, frame_err, overrun, busy);
    end
    rst_n = 1'b1;
    idle(5);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    clear_scoreboard();
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        repeat (DLV - 1) @(posedge clk);
        #1;
        vectors++;
        if (valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_early: valid=%b, required 0", valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (valid !== 1'b1 || dout !== 8'hA5) begin
          miscompares++;
          $display("FAIL basic_deliver: valid=%b dout=%h, required 1 a5", valid, dout);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_drop: valid=%b, required 0", valid);
        end
      end
    join
    idle(5);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'hA5 || fe_cnt != 0 || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL basic_summary: nbytes=%0d fe=%0d ov=%0d, required 1 0 0", obs_q.size(), fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_scoreboard();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy: busy=%b, required 1", busy);
    end
    idle(30);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || fe_cnt != 0 || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL glitch_abort: busy=%b valid=%b fe=%0d ov=%0d, required 0 0 0 0",
               busy, valid, fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_frame_err();
    clear_scoreboard();
    ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(200);
    vectors++;
    if (fe_cnt != 1 || valid !== 1'b0 || busy !== 1'b0 || obs_q.size() != 0 || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL frame_err: fe=%0d valid=%b busy=%b nbytes=%0d ov=%0d, required 1 0 0 0 0",
               fe_cnt, valid, busy, obs_q.size(), ov_cnt);
    end
    rx = 1'b1;
    idle(20);
  endtask

  task automatic test_overrun();
    clear_scoreboard();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(10);
    vectors++;
    if (valid !== 1'b1 || dout !== 8'h11 || ov_cnt != 1 || fe_cnt != 0) begin
      miscompares++;
      $display("FAIL overrun_hold: valid=%b dout=%h ov=%0d fe=%0d, required 1 11 1 0",
               valid, dout, ov_cnt, fe_cnt);
    end
    ready = 1'b1;
    idle(3);
    vectors++;
    if (valid !== 1'b0 || obs_q.size() != 1 || obs_q[0] !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_consume: valid=%b nbytes=%0d, required 0 1 (11)", valid, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_scoreboard();
    ready = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    fork
      begin
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
      end
      begin
        repeat (DLV + 10 * C - 1) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        vectors++;
        if (valid !== 1'b1 || dout !== 8'hAA) begin
          miscompares++;
          $display("FAIL b2b_swap: valid=%b dout=%h, required 1 aa", valid, dout);
        end
      end
    join
    ready = 1'b1;
    idle(3);
    vectors++;
    if (obs_q.size() != exp_q.size() || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL b2b_count: nbytes=%0d ov=%0d, required %0d 0", obs_q.size(), ov_cnt, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_scoreboard();
    ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(5);
    rx = 1'b0;
    idle(C);
    rx = 1'b1;
    idle(4 * C + 8);
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_pre: busy=%b valid=%b, required 1 1", busy, valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dout, valid, frame_err, overrun, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL midframe_reset: dout=%h valid=%b fe=%b ov=%b busy=%b, required all 0",
               dout, valid, frame_err, overrun, busy);
    end
    idle(5);
    rst_n = 1'b1;
    idle(20);
    ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1);
    idle(10);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'h81 || fe_cnt != 0 || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL midframe_recover: nbytes=%0d fe=%0d ov=%0d, required 1 (81) 0 0",
               obs_q.size(), fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_random();
    int exp_fe;
    logic [7:0] b;
    logic good;
    clear_scoreboard();
    exp_fe = 0;
    ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, 1'b1);
      if (good) exp_q.push_back(b);
      else      exp_fe++;
      idle($urandom_range(2, 20));
    end
    idle(5);
    vectors++;
    if (obs_q.size() != exp_q.size() || fe_cnt != exp_fe || ov_cnt != 0) begin
      miscompares++;
      $display("FAIL random_count: nbytes=%0d fe=%0d ov=%0d, required %0d %0d 0",
               obs_q.size(), fe_cnt, ov_cnt, exp_q.size(), exp_fe);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
